// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO result registers and a fixed, parameterised latency per operation.
// Operands are captured when a request is accepted; the result is committed when the latency counter expires.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic             r_signed, w_signed_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic             r_done, w_done_nxt;
  logic             r_div_zero, w_div_zero_nxt;

  // Multiply: extend both operands to 2*WIDTH so one unsigned multiplier serves mult and multu.
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_product;

  assign w_mul_a   = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_mul_b   = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_product = w_mul_a * w_mul_b;

  // Divide on magnitudes; the most negative dividend over -1 wraps back to itself with remainder 0.
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_b_div;
  logic [WIDTH-1:0] w_quo_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_a_neg   = r_signed & r_a[WIDTH-1];
  assign w_b_neg   = r_signed & r_b[WIDTH-1];
  assign w_b_zero  = (r_b == '0);
  assign w_a_mag   = w_a_neg ? -r_a : r_a;
  assign w_b_mag   = w_b_neg ? -r_b : r_b;
  assign w_b_div   = w_b_zero ? WIDTH'(1) : w_b_mag;
  assign w_quo_mag = w_a_mag / w_b_div;
  assign w_rem_mag = w_a_mag % w_b_div;
  assign w_quo     = (w_a_neg ^ w_b_neg) ? -w_quo_mag : w_quo_mag;
  assign w_rem     = w_a_neg ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_signed   <= w_signed_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_done     <= w_done_nxt;
      r_div_zero <= w_div_zero_nxt;
    end
  end

  // Flush overrides everything, including a start in IDLE and a result due on the same edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_signed_nxt   = r_signed;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_done_nxt     = 1'b0;
    w_div_zero_nxt = r_div_zero;

    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            case (i_op)
              OP_MULT, OP_MULTU: begin
                w_state_nxt    = S_MUL;
                w_cnt_nxt      = MUL_CNT;
                w_a_nxt        = i_src_a;
                w_b_nxt        = i_src_b;
                w_signed_nxt   = (i_op == OP_MULT);
                w_div_zero_nxt = 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                w_state_nxt    = S_DIV;
                w_cnt_nxt      = DIV_CNT;
                w_a_nxt        = i_src_a;
                w_b_nxt        = i_src_b;
                w_signed_nxt   = (i_op == OP_DIV);
                w_div_zero_nxt = 1'b0;
              end
              OP_MTHI: w_hi_nxt = i_src_a;
              OP_MTLO: w_lo_nxt = i_src_a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            if (r_state == S_MUL) begin
              w_hi_nxt = w_product[2*WIDTH-1:WIDTH];
              w_lo_nxt = w_product[WIDTH-1:0];
            end else if (w_b_zero) begin
              w_div_zero_nxt = 1'b1;
            end else begin
              w_hi_nxt = w_rem;
              w_lo_nxt = w_quo;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: two instances (32/5/10 and 16/1/18) share one stimulus stream
// and are checked every cycle against a cycle-numbered arithmetic model, plus hand-computed literals.
module tb_mul_div_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Model state: a pending result due on an absolute edge number, plus the visible registers.
  typedef struct {
    bit              pend;
    longint unsigned due;
    bit [63:0]       pHi;
    bit [63:0]       pLo;
    bit              pDz;
    bit [63:0]       hi;
    bit [63:0]       lo;
    bit              dz;
    bit              done;
  } model_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [63:0] a     = 64'd0;
  logic [63:0] b     = 64'd0;

  logic        busyA, doneA, dzA;
  logic [31:0] hiA, loA;
  logic        busyB, doneB, dzB;
  logic [15:0] hiB, loB;

  model_t          mA, mB;
  longint unsigned cyc;
  int              checks   = 0;
  int              failures = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_src_a(a[31:0]), .i_src_b(b[31:0]), .i_flush(flush),
    .o_busy(busyA), .o_done(doneA), .o_div_zero(dzA), .o_hi(hiA), .o_lo(loA)
  );

  mul_div_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(18)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_src_a(a[15:0]), .i_src_b(b[15:0]), .i_flush(flush),
    .o_busy(busyB), .o_done(doneB), .o_div_zero(dzB), .o_hi(hiB), .o_lo(loB)
  );

  function automatic model_t modelReset();
    model_t m;
    m.pend = 1'b0; m.due = 0; m.pHi = '0; m.pLo = '0; m.pDz = 1'b0;
    m.hi = '0; m.lo = '0; m.dz = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  // One clock edge of the architectural behaviour, using plain 64-bit arithmetic for the results.
  function automatic void modelStep(input int w, input int ml, input int dl, input longint unsigned c,
                                    input bit st, input bit [2:0] o, input bit [63:0] ra,
                                    input bit [63:0] rb, input bit fl, inout model_t m);
    bit [63:0] mask, ua, ub, prod;
    longint    sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua   = ra & mask;
    ub   = rb & mask;
    sa   = longint'(ua << (64 - w)) >>> (64 - w);
    sb   = longint'(ub << (64 - w)) >>> (64 - w);
    m.done = 1'b0;
    if (fl) begin
      m.pend = 1'b0;
    end else if (m.pend) begin
      if (c == m.due) begin
        m.pend = 1'b0;
        m.done = 1'b1;
        if (m.pDz) m.dz = 1'b1;
        else begin
          m.hi = m.pHi;
          m.lo = m.pLo;
        end
      end
    end else if (st) begin
      case (o)
        OP_MULT, OP_MULTU: begin
          prod   = (o == OP_MULT) ? 64'(sa * sb) : ua * ub;
          m.pHi  = (prod >> w) & mask;
          m.pLo  = prod & mask;
          m.pDz  = 1'b0;
          m.pend = 1'b1;
          m.due  = c + longint'(ml);
          m.dz   = 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          if (ub == 0) begin
            m.pDz = 1'b1;
          end else begin
            m.pDz = 1'b0;
            if (o == OP_DIV) begin
              q = sa / sb;
              r = sa % sb;
            end else begin
              q = longint'(ua / ub);
              r = longint'(ua % ub);
            end
            m.pLo = 64'(q) & mask;
            m.pHi = 64'(r) & mask;
          end
          m.pend = 1'b1;
          m.due  = c + longint'(dl);
          m.dz   = 1'b0;
        end
        OP_MTHI: m.hi = ua;
        OP_MTLO: m.lo = ua;
        default: ;
      endcase
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Drives one request for exactly one sampling edge, then scrambles the operand buses.
  task automatic applyStimulus(input logic [2:0] o, input logic [63:0] va, input logic [63:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
  endtask

  task automatic waitIdle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busyA && !busyB) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({name, ".idleReached"}, 64'(ok), 64'd1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".busyA"}, 64'(busyA), 64'd0);
    checkOutput({name, ".doneA"}, 64'(doneA), 64'd0);
    checkOutput({name, ".dzA"},   64'(dzA),   64'd0);
    checkOutput({name, ".hiA"},   64'(hiA),   64'd0);
    checkOutput({name, ".loA"},   64'(loA),   64'd0);
    checkOutput({name, ".busyB"}, 64'(busyB), 64'd0);
    checkOutput({name, ".doneB"}, 64'(doneB), 64'd0);
    checkOutput({name, ".dzB"},   64'(dzB),   64'd0);
    checkOutput({name, ".hiB"},   64'(hiB),   64'd0);
    checkOutput({name, ".loB"},   64'(loB),   64'd0);
  endtask

  // Model advances on the same edges the DUTs sample, and clears with the asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA  = modelReset();
      mB  = modelReset();
      cyc = 0;
    end else begin
      cyc++;
      modelStep(32, 5, 10, cyc, start, op, a, b, flush, mA);
      modelStep(16, 1, 18, cyc, start, op, a, b, flush, mB);
    end
  end

  // Every cycle out of reset, both DUTs must match the model on all outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc.busyA", 64'(busyA), 64'(mA.pend));
      checkOutput("cyc.doneA", 64'(doneA), 64'(mA.done));
      checkOutput("cyc.dzA",   64'(dzA),   64'(mA.dz));
      checkOutput("cyc.hiA",   64'(hiA),   mA.hi);
      checkOutput("cyc.loA",   64'(loA),   mA.lo);
      checkOutput("cyc.busyB", 64'(busyB), 64'(mB.pend));
      checkOutput("cyc.doneB", 64'(doneB), 64'(mB.done));
      checkOutput("cyc.dzB",   64'(dzB),   64'(mB.dz));
      checkOutput("cyc.hiB",   64'(hiB),   mB.hi);
      checkOutput("cyc.loB",   64'(loB),   mB.lo);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with literal expectations, then a random phase checked by the model.
  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    applyStimulus(OP_MULT, 64'hFFFF_FFFF, 64'd2);
    n = 0;
    while (busyA && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mult.busyCycles", 64'(n), 64'd5);
    checkOutput("mult.doneA", 64'(doneA), 64'd1);
    waitIdle("mult");
    checkOutput("mult.hiA", 64'(hiA), 64'hFFFF_FFFF);
    checkOutput("mult.loA", 64'(loA), 64'hFFFF_FFFE);
    checkOutput("mult.hiB", 64'(hiB), 64'hFFFF);
    checkOutput("mult.loB", 64'(loB), 64'hFFFE);

    applyStimulus(OP_DIV, 64'hFFFF_FFF9, 64'd2);
    waitIdle("div");
    checkOutput("div.loA", 64'(loA), 64'hFFFF_FFFD);
    checkOutput("div.hiA", 64'(hiA), 64'hFFFF_FFFF);
    checkOutput("div.loB", 64'(loB), 64'hFFFD);
    checkOutput("div.hiB", 64'(hiB), 64'hFFFF);

    applyStimulus(OP_DIVU, 64'd7, 64'd2);
    waitIdle("divu");
    checkOutput("divu.loA", 64'(loA), 64'd3);
    checkOutput("divu.hiA", 64'(hiA), 64'd1);
    checkOutput("divu.loB", 64'(loB), 64'd3);
    checkOutput("divu.hiB", 64'(hiB), 64'd1);

    applyStimulus(OP_MTHI, 64'h11, 64'd0);
    applyStimulus(OP_MTLO, 64'h22, 64'd0);
    checkOutput("mtx.busyA", 64'(busyA), 64'd0);
    checkOutput("mtx.hiA", 64'(hiA), 64'h11);
    checkOutput("mtx.loA", 64'(loA), 64'h22);
    applyStimulus(OP_DIVU, 64'd7, 64'd0);
    waitIdle("dz");
    checkOutput("dz.hiA", 64'(hiA), 64'h11);
    checkOutput("dz.loA", 64'(loA), 64'h22);
    checkOutput("dz.flagA", 64'(dzA), 64'd1);
    checkOutput("dz.hiB", 64'(hiB), 64'h11);
    checkOutput("dz.loB", 64'(loB), 64'h22);
    checkOutput("dz.flagB", 64'(dzB), 64'd1);
    applyStimulus(OP_MULTU, 64'd3, 64'd4);
    checkOutput("dzClear.flagA", 64'(dzA), 64'd0);
    checkOutput("dzClear.flagB", 64'(dzB), 64'd0);
    waitIdle("dzClear");
    checkOutput("dzClear.loA", 64'(loA), 64'd12);

    applyStimulus(OP_MTHI, 64'h55, 64'd0);
    applyStimulus(OP_MTLO, 64'h66, 64'd0);
    applyStimulus(OP_MULTU, 64'd3, 64'd4);
    applyStimulus(OP_MTLO, 64'hABCD, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush.busyA", 64'(busyA), 64'd0);
    checkOutput("flush.doneA", 64'(doneA), 64'd0);
    checkOutput("flush.hiA", 64'(hiA), 64'h55);
    checkOutput("flush.loA", 64'(loA), 64'h66);
    repeat (6) @(negedge clk);
    checkOutput("flush.laterLoA", 64'(loA), 64'h66);
    checkOutput("flush.loB", 64'(loB), 64'd12);

    flush = 1'b1;
    applyStimulus(OP_MTHI, 64'h99, 64'd0);
    flush = 1'b0;
    checkOutput("flushStart.hiA", 64'(hiA), 64'h55);
    checkOutput("flushStart.hiB", 64'(hiB), 64'd0);

    applyStimulus(OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF);
    waitIdle("ovfA");
    checkOutput("ovfA.lo", 64'(loA), 64'h8000_0000);
    checkOutput("ovfA.hi", 64'(hiA), 64'd0);
    checkOutput("ovfA.dz", 64'(dzA), 64'd0);
    applyStimulus(OP_DIV, 64'h8000, 64'hFFFF_FFFF);
    waitIdle("ovfB");
    checkOutput("ovfB.loA", 64'(loA), 64'hFFFF_8000);
    checkOutput("ovfB.loB", 64'(loB), 64'h8000);
    checkOutput("ovfB.hiB", 64'(hiB), 64'd0);

    applyStimulus(OP_MULTU, 64'd5, 64'd6);
    n = 0;
    while (!doneA && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("b2b.doneA", 64'(doneA), 64'd1);
    checkOutput("b2b.firstLoA", 64'(loA), 64'd30);
    applyStimulus(OP_MULTU, 64'd7, 64'd8);
    checkOutput("b2b.busyA", 64'(busyA), 64'd1);
    waitIdle("b2b");
    checkOutput("b2b.loA", 64'(loA), 64'd56);
    checkOutput("b2b.loB", 64'(loB), 64'd56);

    applyStimulus(OP_DIV, 64'd100, 64'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_MULTU, 64'd9, 64'd9);
    checkOutput("postReset.busyA", 64'(busyA), 64'd1);
    waitIdle("postReset");
    checkOutput("postReset.loA", 64'(loA), 64'd81);
    checkOutput("postReset.loB", 64'(loB), 64'd81);

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 64'h8000_0000;
        1:       a = 64'h8000;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1:       b = '1;
        default: b = {$urandom, $urandom};
      endcase
      flush = ($urandom_range(0, 40) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
    waitIdle("random");
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
